// File: rtl/pd_pluse_pkg.sv
// Shared FSM encoding and index-width helper for the PD pulse sequencer.
package pd_pluse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pd_pluse_table.sv
// Segment table: DEPTH x {duration, pattern}, one synchronous write port and
// one combinational read port. Contents are deliberately left unreset.
module pd_pluse_table #(
  parameter int CH    = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int IW    = 4
) (
  input  logic             clk_sys,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_addr_i,
  input  logic [CNT_W-1:0] wr_dur_i,
  input  logic [CH-1:0]    wr_pat_i,
  input  logic [IW-1:0]    rd_addr_i,
  output logic [CNT_W-1:0] rd_dur_o,
  output logic [CH-1:0]    rd_pat_o
);

  logic [CNT_W-1:0] dur_q [DEPTH];
  logic [CH-1:0]    pat_q [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (wr_en_i) begin
      dur_q[wr_addr_i] <= wr_dur_i;
      pat_q[wr_addr_i] <= wr_pat_i;
    end
  end

  assign rd_dur_o = dur_q[rd_addr_i];
  assign rd_pat_o = pat_q[rd_addr_i];

endmodule

// File: rtl/pd_pluse_seq.sv
// PD pulse sequencer: plays seq_len table segments per pass, rep_cnt passes
// (0 = until abort). Outputs are registered; segment changes land 1 cycle after the last tick.
module pd_pluse_seq
  import pd_pluse_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 16,
  parameter  int REP_W = 8,
  localparam int IW    = idx_w(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [IW-1:0]    load_addr,
  input  logic [CNT_W-1:0] load_dur,
  input  logic [CH-1:0]    load_pat,
  input  logic [IW:0]      seq_len,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic             pluse_start,
  input  logic             abort,
  output logic [CH-1:0]    en,
  output logic             busy,
  output logic [IW-1:0]    seg_idx,
  output logic             done,
  output logic             load_err
);

  localparam logic [IW:0] LEN_MAX = (IW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dur0_q, dur0_d;
  logic [CH-1:0]    en_q, en_d, pat0_q, pat0_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [IW:0]      len_q, len_d, nxt, len_clamp;
  logic [IW-1:0]    idx_q, idx_d, rd_addr;
  logic [CNT_W-1:0] rd_dur;
  logic [CH-1:0]    rd_pat;
  logic             load_err_q, load_err_d, wr_en, last_seg;

  assign len_clamp = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
  assign nxt       = {1'b0, idx_q} + (IW+1)'(1);
  assign last_seg  = (nxt >= len_q);
  assign rd_addr   = (state_q == ST_RUN) ? nxt[IW-1:0] : '0;
  assign wr_en     = load && (state_q == ST_IDLE);

  pd_pluse_table #(.CH(CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .IW(IW)) u_table (
    .clk_sys   (clk_sys),
    .wr_en_i   (wr_en),
    .wr_addr_i (load_addr),
    .wr_dur_i  (load_dur),
    .wr_pat_i  (load_pat),
    .rd_addr_i (rd_addr),
    .rd_dur_o  (rd_dur),
    .rd_pat_o  (rd_pat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dur0_d     = dur0_q;
    pat0_d     = pat0_q;
    en_d       = en_q;
    pass_d     = pass_q;
    len_d      = len_q;
    idx_d      = idx_q;
    load_err_d = load && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (pluse_start) begin
          // Entry 0 is captured here so later passes replay what this start saw.
          len_d  = len_clamp;
          pass_d = rep_cnt;
          dur0_d = rd_dur;
          pat0_d = rd_pat;
          idx_d  = '0;
          cnt_d  = rd_dur;
          if (rd_dur == '0 || len_clamp == '0) begin
            state_d = ST_FINISH;
            en_d    = '0;
          end else begin
            state_d = ST_RUN;
            en_d    = rd_pat;
          end
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            if (!last_seg && rd_dur != '0) begin
              idx_d = nxt[IW-1:0];
              en_d  = rd_pat;
              cnt_d = rd_dur;
            end else if (pass_q == REP_W'(1)) begin
              state_d = ST_FINISH;
              en_d    = '0;
              idx_d   = '0;
              cnt_d   = '0;
              pass_d  = '0;
            end else begin
              // pass_q == 0 only in loop-forever mode, where it stays pinned at 0.
              if (pass_q != '0) pass_d = pass_q - REP_W'(1);
              idx_d = '0;
              en_d  = pat0_q;
              cnt_d = dur0_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        en_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      en_d    = '0;
      idx_d   = '0;
      cnt_d   = '0;
      pass_d  = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dur0_q     <= '0;
      pat0_q     <= '0;
      en_q       <= '0;
      pass_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dur0_q     <= dur0_d;
      pat0_q     <= pat0_d;
      en_q       <= en_d;
      pass_q     <= pass_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      load_err_q <= load_err_d;
    end
  end

  assign en       = en_q;
  assign busy     = (state_q == ST_RUN);
  assign seg_idx  = idx_q;
  assign done     = (state_q == ST_FINISH);
  assign load_err = load_err_q;

endmodule
